// File: rtl/doodle_pkg.sv
// Shared encodings and default geometry for the Doodle-Jump game core.
package doodle_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RISE = 2'd1,
        ST_FALL = 2'd2,
        ST_OVER = 2'd3
    } game_state_t;

    localparam logic [11:0] BLACK = 12'h000;
    localparam logic [11:0] WHITE = 12'hFFF;
    localparam logic [11:0] RED   = 12'hF00;
    localparam logic [11:0] GREEN = 12'h0F0;

    localparam int DEF_NUM_PLATFORMS = 8;
    localparam int DEF_PLAT_W        = 64;
    localparam int DEF_PLAT_H        = 16;
    localparam int DEF_DOODLE_R      = 10;
    localparam int DEF_H_MIN         = 144;
    localparam int DEF_H_MAX         = 783;
    localparam int DEF_V_MIN         = 35;
    localparam int DEF_V_MAX         = 515;

    // Platform 0 sits directly under the doodle; the rest are staggered upward.
    function automatic logic [9:0] plat_init_x(int idx, int plat0_x, int h_min, int xspan);
        return (idx == 0) ? 10'(plat0_x) : 10'(h_min + ((idx * 173) % xspan));
    endfunction

    function automatic logic [9:0] plat_init_y(int idx, int plat0_y, int spacing);
        return 10'(plat0_y - idx * spacing);
    endfunction

endpackage

// File: rtl/doodle_game_engine_if.sv
// Control inputs, scan position and game outputs of the game core.
interface doodle_game_engine_if;
    logic        game_tick;
    logic        start;
    logic        left;
    logic        right;
    logic [3:0]  tilt_intensity;
    logic [9:0]  hCount;
    logic [9:0]  vCount;
    logic        bright;
    logic [11:0] rgb;
    logic [9:0]  xpos;
    logic [9:0]  ypos;
    logic [15:0] score;
    logic [1:0]  state;
    logic        game_over;

    modport master (
        output game_tick, start, left, right, tilt_intensity, hCount, vCount, bright,
        input  rgb, xpos, ypos, score, state, game_over
    );

    modport slave (
        input  game_tick, start, left, right, tilt_intensity, hCount, vCount, bright,
        output rgb, xpos, ypos, score, state, game_over
    );
endinterface

// File: rtl/doodle_lfsr.sv
// 10-bit Galois LFSR, polynomial x^10 + x^7 + 1, used for platform respawn x.
module doodle_lfsr #(
    parameter logic [9:0] SEED = 10'h1A5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [9:0] value
);

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= SEED;
        end else if (en) begin
            value <= value[0] ? ((value >> 1) ^ 10'h240) : (value >> 1);
        end
    end

endmodule

// File: rtl/doodle_game_engine.sv
// Doodle-Jump game core: jump physics, platform table, scrolling, recycling,
// scoring and registered pixel colour.
//
// state | meaning
// IDLE  | waiting for start, world at initial layout
// RISE  | ascending; scrolls the world once the doodle reaches SCROLL_LINE
// FALL  | descending; lands on the lowest-index platform crossed this tick
// OVER  | fell off the bottom; frozen until start
module doodle_game_engine
    import doodle_pkg::*;
#(
    parameter int NUM_PLATFORMS = DEF_NUM_PLATFORMS,
    parameter int PLAT_W        = DEF_PLAT_W,
    parameter int PLAT_H        = DEF_PLAT_H,
    parameter int DOODLE_R      = DEF_DOODLE_R,
    parameter int H_MIN         = DEF_H_MIN,
    parameter int H_MAX         = DEF_H_MAX,
    parameter int V_MIN         = DEF_V_MIN,
    parameter int V_MAX         = DEF_V_MAX,
    parameter int START_X       = 406,
    parameter int START_Y       = 477,
    parameter int JUMP_HEIGHT   = 120,
    parameter int STEP          = 2,
    parameter int SCROLL_LINE   = 200,
    parameter logic [9:0] LFSR_SEED = 10'h1A5
) (
    input logic clk,
    input logic rst,
    doodle_game_engine_if.slave bus
);

    localparam int SPACING = (V_MAX - V_MIN) / NUM_PLATFORMS;
    localparam int XSPAN   = H_MAX - H_MIN + 1 - PLAT_W;
    localparam int PLAT0_X = START_X - PLAT_W / 2;
    localparam int PLAT0_Y = START_Y + DOODLE_R + 1;

    game_state_t state_q, state_d;
    logic [9:0]  x_q, x_d, y_q, y_d, rise_q, rise_d;
    logic [15:0] score_q, score_d;
    logic [11:0] rgb_q, rgb_d;
    logic [9:0]  px_q [NUM_PLATFORMS];
    logic [9:0]  px_d [NUM_PLATFORMS];
    logic [9:0]  py_q [NUM_PLATFORMS];
    logic [9:0]  py_d [NUM_PLATFORMS];
    logic        init_all;

    logic [9:0]  lfsr, off;
    logic [10:0] x_move;
    logic        hit;
    logic [9:0]  hit_y;
    logic        in_doodle, in_plat;
    logic [11:0] pix;

    doodle_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .en    (1'b1),
        .value (lfsr)
    );

    // lfsr < 2*XSPAN, so one conditional subtract is a full modulo.
    assign off = (lfsr >= 10'(XSPAN)) ? lfsr - 10'(XSPAN) : lfsr;

    always_comb begin
        x_move = {1'b0, x_q};
        if (bus.right && !bus.left) begin
            x_move = {1'b0, x_q} + {7'd0, bus.tilt_intensity};
            if (x_move > 11'(H_MAX)) x_move = 11'(H_MIN);
        end else if (bus.left && !bus.right) begin
            x_move = {1'b0, x_q} - {7'd0, bus.tilt_intensity};
            if (x_move < 11'(H_MIN)) x_move = 11'(H_MAX);
        end
    end

    // Descending scan so the lowest index is the last (winning) assignment.
    always_comb begin
        hit   = 1'b0;
        hit_y = '0;
        for (int i = NUM_PLATFORMS - 1; i >= 0; i--) begin
            if (({1'b0, y_q} + 11'(DOODLE_R) < {1'b0, py_q[i]}) &&
                ({1'b0, y_q} + 11'(DOODLE_R + STEP) >= {1'b0, py_q[i]}) &&
                ({1'b0, x_q} + 11'(DOODLE_R) >= {1'b0, px_q[i]}) &&
                ({1'b0, x_q} - 11'(DOODLE_R) <= {1'b0, px_q[i]} + 11'(PLAT_W - 1))) begin
                hit   = 1'b1;
                hit_y = py_q[i];
            end
        end
    end

    always_comb begin
        in_doodle = ({1'b0, bus.hCount} + 11'(DOODLE_R) >= {1'b0, x_q}) &&
                    ({1'b0, bus.hCount} <= {1'b0, x_q} + 11'(DOODLE_R)) &&
                    ({1'b0, bus.vCount} + 11'(DOODLE_R) >= {1'b0, y_q}) &&
                    ({1'b0, bus.vCount} <= {1'b0, y_q} + 11'(DOODLE_R));
        in_plat = 1'b0;
        for (int i = 0; i < NUM_PLATFORMS; i++) begin
            if (({1'b0, bus.hCount} >= {1'b0, px_q[i]}) &&
                ({1'b0, bus.hCount} <= {1'b0, px_q[i]} + 11'(PLAT_W - 1)) &&
                ({1'b0, bus.vCount} >= {1'b0, py_q[i]}) &&
                ({1'b0, bus.vCount} <= {1'b0, py_q[i]} + 11'(PLAT_H - 1))) begin
                in_plat = 1'b1;
            end
        end
        pix = BLACK;
        if (!bus.bright)             pix = BLACK;
        else if (state_q == ST_OVER) pix = RED;
        else if (in_doodle)          pix = RED;
        else if (in_plat)            pix = GREEN;
    end

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        rise_d   = rise_q;
        score_d  = score_q;
        px_d     = px_q;
        py_d     = py_q;
        rgb_d    = pix;
        init_all = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_RISE;
                    rise_d  = 10'(JUMP_HEIGHT);
                end
            end
            ST_RISE: begin
                if (bus.game_tick) begin
                    x_d = x_move[9:0];
                    if (y_q > 10'(SCROLL_LINE)) begin
                        y_d = y_q - 10'(STEP);
                    end else begin
                        score_d = (score_q > 16'hFFFF - 16'(STEP)) ? 16'hFFFF : score_q + 16'(STEP);
                        for (int i = 0; i < NUM_PLATFORMS; i++) begin
                            py_d[i] = py_q[i] + 10'(STEP);
                            if ({1'b0, py_q[i]} + 11'(STEP) > 11'(V_MAX)) begin
                                py_d[i] = 10'(V_MIN);
                                px_d[i] = 10'(H_MIN) + off;
                            end
                        end
                    end
                    if (rise_q <= 10'(STEP)) begin
                        rise_d  = '0;
                        state_d = ST_FALL;
                    end else begin
                        rise_d = rise_q - 10'(STEP);
                    end
                end
            end
            ST_FALL: begin
                if (bus.game_tick) begin
                    x_d = x_move[9:0];
                    if (hit) begin
                        y_d     = hit_y - 10'(DOODLE_R + 1);
                        rise_d  = 10'(JUMP_HEIGHT);
                        state_d = ST_RISE;
                    end else begin
                        y_d = y_q + 10'(STEP);
                        if ({1'b0, y_q} + 11'(STEP + DOODLE_R) > 11'(V_MAX)) state_d = ST_OVER;
                    end
                end
            end
            ST_OVER: begin
                if (bus.start) begin
                    init_all = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || init_all) begin
            state_q <= ST_IDLE;
            x_q     <= 10'(START_X);
            y_q     <= 10'(START_Y);
            rise_q  <= '0;
            score_q <= '0;
            rgb_q   <= BLACK;
            for (int i = 0; i < NUM_PLATFORMS; i++) begin
                px_q[i] <= plat_init_x(i, PLAT0_X, H_MIN, XSPAN);
                py_q[i] <= plat_init_y(i, PLAT0_Y, SPACING);
            end
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            rise_q  <= rise_d;
            score_q <= score_d;
            rgb_q   <= rgb_d;
            px_q    <= px_d;
            py_q    <= py_d;
        end
    end

    assign bus.rgb       = rgb_q;
    assign bus.xpos      = x_q;
    assign bus.ypos      = y_q;
    assign bus.score     = score_q;
    assign bus.state     = state_q;
    assign bus.game_over = (state_q == ST_OVER);

endmodule

// File: doc/doodle_game_engine.md
Name: doodle_game_engine

Overview:
Parametrised game core for the Doodle-Jump VGA design. It replaces fixed, hard-coded platform painting with a jump-physics state machine, a platform table of NUM_PLATFORMS entries, camera scrolling, platform recycling via LFSR, collision detection, scoring and a registered pixel colour output. It sits between the tilt/button input logic and the display controller, which supplies hCount/vCount/bright.

Parameters:
NUM_PLATFORMS, 8, number of platform slots
PLAT_W, 64, platform width (px)
PLAT_H, 16, platform height (px)
DOODLE_R, 10, doodle half-size (px)
H_MIN, 144, first visible hCount
H_MAX, 783, last visible hCount
V_MIN, 35, first visible vCount
V_MAX, 515, last visible vCount
START_X, 406, doodle start x
START_Y, 477, doodle start y
JUMP_HEIGHT, 120, px risen per jump
STEP, 2, vertical px per game tick
SCROLL_LINE, 200, doodle y at or above which the world scrolls instead of the doodle
LFSR_SEED, 10'h1A5, nonzero LFSR reset value

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
game_tick  in  1  one-cycle motion-enable pulse (once per frame)
start  in  1  one-cycle start/restart pulse
left  in  1  move left
right  in  1  move right
tilt_intensity  in  4  horizontal px per tick (0..15)
hCount  in  10  current pixel column
vCount  in  10  current pixel row
bright  in  1  visible-area flag
rgb  out  12  pixel colour, registered
xpos  out  10  doodle centre x
ypos  out  10  doodle centre y
score  out  16  height climbed, saturating
state  out  2  IDLE=0 RISE=1 FALL=2 OVER=3
game_over  out  1  high when state==OVER

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high and overrides every other input, including game_tick and start.
- Reset / IDLE init values:
  - state=IDLE, xpos=START_X, ypos=START_Y, score=0, rgb=0, rise_cnt=0, LFSR=LFSR_SEED.
  - Platform 0: x=START_X-PLAT_W/2, y=START_Y+DOODLE_R+1 (374, 488).
  - Platform i≥1: y=488-i*SPACING, where SPACING=(V_MAX-V_MIN)/NUM_PLATFORMS=60; x=H_MIN+((i*173) mod XSPAN), where XSPAN=H_MAX-H_MIN+1-PLAT_W=576.
- Motion gating: positions, platforms and score change only on cycles with game_tick=1.
- Start: start has priority over game_tick in the same cycle. It performs only the state change, with no motion that cycle.
- FSM:
  - IDLE: start -> RISE, rise_cnt=JUMP_HEIGHT.
  - RISE, each tick:
    - If ypos>SCROLL_LINE: ypos-=STEP.
    - Otherwise all platform y+=STEP and score+=STEP (saturate at 16'hFFFF).
    - rise_cnt-=STEP; when it reaches 0 -> FALL.
  - FALL, each tick, hit is tested first on the pre-move values:
    - Hit condition: ypos+DOODLE_R<plat_y, ypos+DOODLE_R+STEP>=plat_y, xpos+DOODLE_R>=plat_x and xpos-DOODLE_R<=plat_x+PLAT_W-1.
    - Hit: ypos=plat_y-DOODLE_R-1, rise_cnt=JUMP_HEIGHT -> RISE. If several platforms hit, the lowest index wins.
    - No hit: ypos+=STEP. If the new ypos+DOODLE_R>V_MAX -> OVER.
  - OVER: everything frozen. start re-initialises all values to the reset values except the LFSR -> IDLE.
- Horizontal (RISE/FALL ticks only):
  - Use 11-bit arithmetic.
  - right and not left: x+=tilt; if the result >H_MAX, x=H_MIN.
  - left and not right: x-=tilt; if the result <H_MIN, x=H_MAX.
  - Both or neither: no change.
- Recycling:
  - After a scroll update, any platform with y>V_MAX respawns at y=V_MIN.
  - Its x=H_MIN+off, where off=(lfsr>=XSPAN)?lfsr-XSPAN:lfsr.
  - All platforms respawned on the same tick take the same off.
- LFSR: 10-bit Galois, polynomial x^10+x^7+1. It advances every clk cycle, ungated, and is never zero.
- Colour:
  - rgb is registered, with 1-cycle latency from hCount/vCount; the integrator delays syncs by 1.
  - Priority: ~bright BLACK; OVER RED; inside doodle box (|h-x|<=R, |v-y|<=R) RED; inside any platform rectangle GREEN; otherwise BLACK.
  - IDLE renders normally.

Decomposition:
- doodle_pkg: state encoding, colour constants (BLACK/WHITE/RED/GREEN), default screen-bound constants.
- Sub-module doodle_lfsr: 10-bit Galois LFSR with seed parameter, enable and synchronous reset.

Test Plan:
- Reset: rst for 2 clocks -> state=0, xpos=406, ypos=477, score=0; the bright=1 pixel at (406,477) has rgb=12'hF00 one cycle later.
- Jump apex: start, then 60 ticks -> ypos=357, state=FALL, score=0.
- Landing: continue with no input; at FALL tick 61 -> ypos=477, state=RISE, no scroll.
- Scroll: force ypos=200 in RISE, one tick -> ypos=200, every platform y+2, score=2. Platform at y=514 -> respawns y=35 with x in [144,719].
- Wrap: xpos=780, right, tilt=8, tick -> xpos=144. xpos=146, left, tilt=8 -> xpos=783.
- Fall-off and restart:
  - Move doodle off all platforms and fall until ypos+10>515 -> state=OVER, game_over=1, every visible pixel 12'hF00.
  - start -> IDLE with reset values.
  - rst asserted mid-RISE together with game_tick -> reset values next cycle.
